// File: rtl/demux1to2_32_buf.sv
// 1-to-2 demultiplexer with one registered slot per output port (valid/ready on all sides).
// Define DEMUX_CNT_EN to add 16-bit completed-transfer counters a_count / b_count.
module demux1to2_32_buf #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sel,
   input  logic [WIDTH-1:0] in_data,
   output logic             a_valid,
   input  logic             a_ready,
   output logic [WIDTH-1:0] a_data,
   output logic             b_valid,
   input  logic             b_ready,
`ifdef DEMUX_CNT_EN
   output logic [WIDTH-1:0] b_data,
   output logic [15:0]      a_count,
   output logic [15:0]      b_count
`else
   output logic [WIDTH-1:0] b_data
`endif
);

   typedef enum logic {StEmpty, StFull} slot_e;

   slot_e            a_state_q, a_state_d;
   slot_e            b_state_q, b_state_d;
   logic [WIDTH-1:0] a_data_q, a_data_d;
   logic [WIDTH-1:0] b_data_q, b_data_d;

   logic a_out, b_out;
   logic a_load, b_load;
   logic a_can_take, b_can_take;

   assign a_out = (a_state_q == StFull) & a_ready;
   assign b_out = (b_state_q == StFull) & b_ready;

   // A slot can take a word if empty or if it is draining this very cycle.
   assign a_can_take = (a_state_q == StEmpty) | a_out;
   assign b_can_take = (b_state_q == StEmpty) | b_out;

   assign in_ready = in_sel ? a_can_take : b_can_take;

   assign a_load = in_valid & in_ready & in_sel;
   assign b_load = in_valid & in_ready & ~in_sel;

   always_comb begin
      a_state_d = a_state_q;
      a_data_d  = a_data_q;
      if (a_load) begin
         a_state_d = StFull;
         a_data_d  = in_data;
      end else if (a_out) begin
         a_state_d = StEmpty;
      end
   end

   always_comb begin
      b_state_d = b_state_q;
      b_data_d  = b_data_q;
      if (b_load) begin
         b_state_d = StFull;
         b_data_d  = in_data;
      end else if (b_out) begin
         b_state_d = StEmpty;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_state_q <= StEmpty;
         b_state_q <= StEmpty;
         a_data_q  <= '0;
         b_data_q  <= '0;
      end else begin
         a_state_q <= a_state_d;
         b_state_q <= b_state_d;
         a_data_q  <= a_data_d;
         b_data_q  <= b_data_d;
      end
   end

   assign a_valid = (a_state_q == StFull);
   assign b_valid = (b_state_q == StFull);
   assign a_data  = a_data_q;
   assign b_data  = b_data_q;

`ifdef DEMUX_CNT_EN
   logic [15:0] a_count_q, a_count_d;
   logic [15:0] b_count_q, b_count_d;

   always_comb begin
      a_count_d = a_count_q;
      b_count_d = b_count_q;
      if (a_out) a_count_d = a_count_q + 16'd1;
      if (b_out) b_count_d = b_count_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_count_q <= '0;
         b_count_q <= '0;
      end else begin
         a_count_q <= a_count_d;
         b_count_q <= b_count_d;
      end
   end

   assign a_count = a_count_q;
   assign b_count = b_count_q;
`endif

endmodule

// File: tb/tb_demux1to2_32_buf.sv
// Directed bench for demux1to2_32_buf: vector table plus streaming, reset and counter sequences.
// Counter-wrap sequence is built only when DEMUX_CNT_EN is defined.
module tb_demux1to2_32_buf;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_sel;
   logic [31:0] in_data;
   logic        a_valid;
   logic        a_ready;
   logic [31:0] a_data;
   logic        b_valid;
   logic        b_ready;
   logic [31:0] b_data;
`ifdef DEMUX_CNT_EN
   logic [15:0] a_count;
   logic [15:0] b_count;
`endif

   demux1to2_32_buf #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_sel   (in_sel),
      .in_data  (in_data),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .a_data   (a_data),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
`ifdef DEMUX_CNT_EN
      .b_data   (b_data),
      .a_count  (a_count),
      .b_count  (b_count)
`else
      .b_data   (b_data)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_pass;
   int n_total;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h, want %h", name, act, exp);
      else n_pass++;
   endtask

   // Inputs for one cycle, and outputs expected just before the following edge.
   typedef struct {
      logic        v;
      logic        sel;
      logic [31:0] d;
      logic        ar;
      logic        br;
      logic        exp_rdy;
      logic        exp_av;
      logic [31:0] exp_ad;
      logic        exp_bv;
      logic [31:0] exp_bd;
   } vec_t;

   vec_t vecs[14];

   task automatic drive(input logic v, input logic sel, input logic [31:0] d,
                        input logic ar, input logic br);
      in_valid = v;
      in_sel   = sel;
      in_data  = d;
      a_ready  = ar;
      b_ready  = br;
   endtask

   logic [31:0] exp_a_q[$];
   logic [31:0] exp_b_q[$];
   logic [31:0] words[8];
   int          got_a, got_b;
   logic [31:0] exp_w;

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst_n   = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

      //          v  sel d             ar br  rdy av ad            bv bd
      vecs[0]  = '{1, 1, 32'hDEADBEEF, 1, 1,  1,  0, 32'h0,        0, 32'h0};
      vecs[1]  = '{0, 0, 32'h0,        1, 1,  1,  1, 32'hDEADBEEF, 0, 32'h0};
      vecs[2]  = '{0, 0, 32'h0,        1, 1,  1,  0, 32'h0,        0, 32'h0};
      vecs[3]  = '{1, 0, 32'h1,        1, 0,  1,  0, 32'h0,        0, 32'h0};
      vecs[4]  = '{1, 0, 32'h2,        1, 0,  0,  0, 32'h0,        1, 32'h1};
      vecs[5]  = '{1, 0, 32'h2,        1, 0,  0,  0, 32'h0,        1, 32'h1};
      vecs[6]  = '{1, 0, 32'h2,        1, 1,  1,  0, 32'h0,        1, 32'h1};
      vecs[7]  = '{0, 0, 32'h0,        1, 1,  1,  0, 32'h0,        1, 32'h2};
      vecs[8]  = '{0, 0, 32'h0,        0, 0,  1,  0, 32'h0,        0, 32'h0};
      vecs[9]  = '{1, 1, 32'hA1,       0, 0,  1,  0, 32'h0,        0, 32'h0};
      vecs[10] = '{1, 0, 32'hB1,       0, 0,  1,  1, 32'hA1,       0, 32'h0};
      vecs[11] = '{1, 1, 32'hA2,       0, 0,  0,  1, 32'hA1,       1, 32'hB1};
      vecs[12] = '{0, 1, 32'hCAFEF00D, 1, 1,  1,  1, 32'hA1,       1, 32'hB1};
      vecs[13] = '{0, 0, 32'h0,        0, 0,  1,  0, 32'h0,        0, 32'h0};

      // Reset state
      @(negedge clk);
      #1;
      check("reset a_valid", {31'b0, a_valid}, 32'h0);
      check("reset b_valid", {31'b0, b_valid}, 32'h0);
      check("reset a_data", a_data, 32'h0);
      check("reset b_data", b_data, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         drive(vecs[i].v, vecs[i].sel, vecs[i].d, vecs[i].ar, vecs[i].br);
         #1;
         check($sformatf("vec%0d in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].exp_rdy});
         check($sformatf("vec%0d a_valid", i), {31'b0, a_valid}, {31'b0, vecs[i].exp_av});
         check($sformatf("vec%0d b_valid", i), {31'b0, b_valid}, {31'b0, vecs[i].exp_bv});
         if (vecs[i].exp_av) check($sformatf("vec%0d a_data", i), a_data, vecs[i].exp_ad);
         if (vecs[i].exp_bv) check($sformatf("vec%0d b_data", i), b_data, vecs[i].exp_bd);
      end

      // Streaming: 8 words alternating a/b, both ports always ready
      for (int i = 0; i < 8; i++) words[i] = 32'h5000_0000 + 32'(i * 17 + 3);
      got_a = 0;
      got_b = 0;
      for (int k = 0; k <= 9; k++) begin
         @(negedge clk);
         if (k < 8) begin
            drive(1'b1, (k % 2) == 0, words[k], 1'b1, 1'b1);
            if ((k % 2) == 0) exp_a_q.push_back(words[k]);
            else exp_b_q.push_back(words[k]);
         end else begin
            drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
         end
         #1;
         if (k < 8) check($sformatf("stream%0d in_ready", k), {31'b0, in_ready}, 32'h1);
         if (k >= 1 && k <= 8)
            check($sformatf("stream%0d one valid", k), 32'(a_valid) + 32'(b_valid), 32'h1);
         if (k == 9)
            check("stream drained", {30'b0, a_valid, b_valid}, 32'h0);
         if (a_valid) begin
            exp_w = (exp_a_q.size() > 0) ? exp_a_q.pop_front() : 32'hxxxx_xxxx;
            check($sformatf("stream%0d a_data", k), a_data, exp_w);
            got_a++;
         end
         if (b_valid) begin
            exp_w = (exp_b_q.size() > 0) ? exp_b_q.pop_front() : 32'hxxxx_xxxx;
            check($sformatf("stream%0d b_data", k), b_data, exp_w);
            got_b++;
         end
      end
      check("stream a count", got_a, 32'd4);
      check("stream b count", got_b, 32'd4);

      // Mid-operation reset with both slots full
      @(negedge clk);
      drive(1'b1, 1'b1, 32'h1111_AAAA, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h2222_BBBB, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      #1;
      check("prerst a_valid", {31'b0, a_valid}, 32'h1);
      check("prerst b_valid", {31'b0, b_valid}, 32'h1);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst a_valid", {31'b0, a_valid}, 32'h0);
      check("midrst b_valid", {31'b0, b_valid}, 32'h0);
      check("midrst a_data", a_data, 32'h0);
      check("midrst b_data", b_data, 32'h0);
      @(negedge clk);
      drive(1'b0, 1'b1, 32'h0, 1'b1, 1'b1);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         check($sformatf("postrst%0d valids", k), {30'b0, a_valid, b_valid}, 32'h0);
      end
      @(negedge clk);
      drive(1'b1, 1'b1, 32'h3333_CCCC, 1'b1, 1'b1);
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      #1;
      check("resume a_valid", {31'b0, a_valid}, 32'h1);
      check("resume a_data", a_data, 32'h3333_CCCC);

`ifdef DEMUX_CNT_EN
      // Counter wrap on port a; b must stay put
      @(negedge clk);
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 32'h77, 1'b1, 1'b1);
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      @(negedge clk);
      #1;
      check("cnt b one", {16'b0, b_count}, 32'h1);
      for (int k = 0; k < 65534; k++) begin
         @(negedge clk);
         drive(1'b1, 1'b1, 32'(k), 1'b1, 1'b1);
      end
      @(negedge clk);
      drive(1'b0, 1'b1, 32'h0, 1'b1, 1'b1);
      @(negedge clk);
      #1;
      check("cnt a fffe", {16'b0, a_count}, 32'h0000_FFFE);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         drive(1'b1, 1'b1, 32'(k), 1'b1, 1'b1);
      end
      @(negedge clk);
      drive(1'b0, 1'b1, 32'h0, 1'b1, 1'b1);
      @(negedge clk);
      #1;
      check("cnt a wrap", {16'b0, a_count}, 32'h0);
      check("cnt b kept", {16'b0, b_count}, 32'h1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
